uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, valid/yumi holding register; byte visible ~half a bit after the stop-bit edge.
// No backpressure on the serial line: a byte finishing while the holding register is full is dropped and flagged as overrun.
module uart_rx #(
  parameter int clk_per_bit_p = 10416
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  input  logic       rx_yumi_i,
  output logic       rx_v_o,
  output logic [7:0] rx_o,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o
);

  localparam logic [15:0] half_lp = 16'((clk_per_bit_p - 1) / 2);
  localparam logic [15:0] last_lp = 16'(clk_per_bit_p - 1);

  typedef enum logic [2:0] {
    e_reset,
    e_idle,
    e_start_bit,
    e_data_bits,
    e_stop_bit,
    e_break
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, rx_s_q;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  data_cnt_q, data_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        rx_v_q, rx_v_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        byte_done;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= e_reset;
      clk_cnt_q   <= '0;
      data_cnt_q  <= '0;
      shift_q     <= '0;
      rx_q        <= '0;
      rx_v_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx_i;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      data_cnt_q  <= data_cnt_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      rx_v_q      <= rx_v_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    data_cnt_d  = data_cnt_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      e_reset: begin
        clk_cnt_d  = '0;
        data_cnt_d = '0;
        state_d    = e_idle;
      end
      e_idle: begin
        clk_cnt_d  = '0;
        data_cnt_d = '0;
        if (!rx_s_q) state_d = e_start_bit;
      end
      e_start_bit: begin
        // Mid-start check: a line that is high again here was only a glitch.
        if (clk_cnt_q == half_lp) begin
          clk_cnt_d = '0;
          state_d   = rx_s_q ? e_idle : e_data_bits;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      e_data_bits: begin
        if (clk_cnt_q == last_lp) begin
          clk_cnt_d           = '0;
          shift_d[data_cnt_q] = rx_s_q;
          data_cnt_d          = data_cnt_q + 3'd1;
          if (data_cnt_q == 3'd7) state_d = e_stop_bit;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      e_stop_bit: begin
        if (clk_cnt_q == last_lp) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = e_idle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = e_break;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      e_break: begin
        if (rx_s_q) state_d = e_idle;
      end
      default: state_d = e_reset;
    endcase
  end

  // A yumi in the completion cycle frees the register, so the new byte is loaded rather than dropped.
  always_comb begin
    rx_d      = rx_q;
    rx_v_d    = rx_v_q;
    overrun_d = 1'b0;
    if (byte_done) begin
      if (!rx_v_q || rx_yumi_i) begin
        rx_d   = shift_q;
        rx_v_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_yumi_i) begin
      rx_v_d = 1'b0;
    end
  end

  assign rx_v_o         = rx_v_q;
  assign rx_o           = rx_q;
  assign rx_frame_err_o = frame_err_q;
  assign rx_overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame table plus random frames scored against a queue of expected bytes and error counts,
// with hand-written sequences for glitch, break, overrun and mid-frame reset.
module tb_uart_rx;

  localparam int P = 16;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rx_i;
  logic       rx_yumi_i;
  logic       rx_v_o;
  logic [7:0] rx_o;
  logic       rx_frame_err_o;
  logic       rx_overrun_o;

  logic auto_en, auto_yumi, man_yumi;
  assign rx_yumi_i = auto_yumi | man_yumi;

  uart_rx #(.clk_per_bit_p(P)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .rx_i          (rx_i),
    .rx_yumi_i     (rx_yumi_i),
    .rx_v_o        (rx_v_o),
    .rx_o          (rx_o),
    .rx_frame_err_o(rx_frame_err_o),
    .rx_overrun_o  (rx_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int err_cycles = 0;
  int ovr_cycles = 0;
  int exp_err_n = 0;
  int exp_ovr_n = 0;
  int dly = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model of the host: counts pulse cycles and, in auto mode, consumes bytes in order within 0..2 cycles.
  always @(negedge clk_i) begin
    if (rx_frame_err_o === 1'b1) err_cycles++;
    if (rx_overrun_o === 1'b1) ovr_cycles++;
    if (auto_yumi) begin
      auto_yumi = 1'b0;
      chk("valid_drop_after_yumi", {31'd0, rx_v_o}, 32'd0);
    end else if (auto_en && rx_v_o === 1'b1) begin
      if (dly == 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, rx_o}, 32'hFFFF_FFFF);
        end else begin
          chk("rx_byte", {24'd0, rx_o}, {24'd0, exp_q.pop_front()});
        end
        auto_yumi = 1'b1;
        dly = $urandom_range(2, 0);
      end else begin
        dly--;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      rx_i = 1'b1;
    end
  endtask

  // Sends one frame after gap idle cycles; man_yumi pulses at cycle yumi_at counted from the start-bit edge.
  task automatic send(input logic [7:0] d, input bit stop_hi, input int gap, input int yumi_at);
    logic [9:0] fr;
    logic [3:0] idx;
    fr = {stop_hi, d, 1'b0};
    idle(gap);
    for (int c = 0; c < 10 * P; c++) begin
      @(negedge clk_i);
      idx = 4'(c / P);
      rx_i = fr[idx];
      man_yumi = (c == yumi_at);
    end
    man_yumi = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_hi;
    int         gap;
    bit         exp_byte;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base_err, base_ovr, gap;
    bit bad, prev_bad;
    logic [7:0] d;
    logic [9:0] fr;
    logic [3:0] idx;

    vecs[0] = '{8'h55, 1'b1, 20, 1'b1, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 10, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 1'b1, 0,  1'b1, 1'b0};
    vecs[3] = '{8'hC6, 1'b0, 0,  1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, P,  1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 0,  1'b1, 1'b0};

    rx_i = 1'b1; reset_i = 1'b1; man_yumi = 1'b0; auto_en = 1'b0; auto_yumi = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_rx_v", {31'd0, rx_v_o}, 32'd0);
    chk("reset_rx_o", {24'd0, rx_o}, 32'd0);
    chk("reset_frame_err", {31'd0, rx_frame_err_o}, 32'd0);
    chk("reset_overrun", {31'd0, rx_overrun_o}, 32'd0);
    reset_i = 1'b0;
    auto_en = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].exp_byte) exp_q.push_back(vecs[i].data);
      if (vecs[i].exp_err) exp_err_n++;
      send(vecs[i].data, vecs[i].stop_hi, vecs[i].gap, -1);
    end
    idle(3 * P);
    chk("table_frame_err_cycles", err_cycles, exp_err_n);
    chk("table_bytes_left", exp_q.size(), 0);
    chk("table_overrun_cycles", ovr_cycles, 0);

    // 3-cycle low pulse must be rejected at the mid-start check.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      rx_i = 1'b0;
    end
    idle(4 * P);
    chk("glitch_frame_err_cycles", err_cycles, exp_err_n);

    // Bad stop then a long break: exactly one frame error.
    exp_err_n++;
    send(8'h81, 1'b0, 10, -1);
    repeat (5 * P) @(negedge clk_i);
    chk("break_single_err", err_cycles, exp_err_n);
    idle(2 * P);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 0, -1);
    idle(3 * P);
    chk("after_break_bytes_left", exp_q.size(), 0);

    // Overrun: holding register full and not consumed.
    auto_en = 1'b0;
    base_ovr = ovr_cycles;
    send(8'h11, 1'b1, 10, -1);
    send(8'h22, 1'b1, 10, -1);
    exp_ovr_n++;
    idle(4);
    chk("overrun_pulse", ovr_cycles - base_ovr, 1);
    chk("overrun_keeps_old", {24'd0, rx_o}, 32'h11);
    chk("overrun_valid", {31'd0, rx_v_o}, 32'd1);
    // Completion cycle: 2 sync + 1 idle detect + half bit + 9 bits, counted from the start edge.
    send(8'h22, 1'b1, 10, 3 + (P - 1) / 2 + 9 * P);
    idle(4);
    chk("yumi_at_done_byte", {24'd0, rx_o}, 32'h22);
    chk("yumi_at_done_valid", {31'd0, rx_v_o}, 32'd1);
    chk("yumi_at_done_no_overrun", ovr_cycles - base_ovr, 1);
    @(negedge clk_i); man_yumi = 1'b1;
    @(negedge clk_i); man_yumi = 1'b0;
    chk("manual_yumi_drop", {31'd0, rx_v_o}, 32'd0);

    // Mid-frame reset with a byte held, then a clean frame.
    send(8'h5A, 1'b1, 10, -1);
    idle(4);
    chk("prereset_valid", {31'd0, rx_v_o}, 32'd1);
    chk("prereset_byte", {24'd0, rx_o}, 32'h5A);
    base_err = err_cycles;
    fr = {1'b1, 8'hE7, 1'b0};
    for (int c = 0; c < 6 * P; c++) begin
      @(negedge clk_i);
      if (c == 5 * P + 9) begin
        chk("midreset_rx_v", {31'd0, rx_v_o}, 32'd0);
        chk("midreset_rx_o", {24'd0, rx_o}, 32'd0);
        chk("midreset_frame_err", {31'd0, rx_frame_err_o}, 32'd0);
        chk("midreset_overrun", {31'd0, rx_overrun_o}, 32'd0);
        auto_en = 1'b1;
      end
      reset_i = (c == 5 * P + 8);
      idx = 4'(c / P);
      rx_i = fr[idx];
    end
    idle(3 * P);
    chk("midreset_no_err", err_cycles - base_err, 0);
    exp_q.push_back(8'hE7);
    send(8'hE7, 1'b1, 2 * P, -1);
    idle(3 * P);
    chk("after_reset_bytes_left", exp_q.size(), 0);

    // Random frames; occasional bad stop followed by at least a bit of idle.
    prev_bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      bad = ($urandom_range(5, 0) == 0);
      gap = prev_bad ? P + $urandom_range(P, 0) : $urandom_range(20, 0);
      if (bad) exp_err_n++;
      else exp_q.push_back(d);
      send(d, !bad, gap, -1);
      prev_bad = bad;
    end
    idle(4 * P);
    chk("final_frame_err_cycles", err_cycles, exp_err_n);
    chk("final_overrun_cycles", ovr_cycles, exp_ovr_n);
    chk("final_bytes_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
